// File: rtl/fpu_cmd_issuer.sv
// Command front-end for the FPU: queues operation requests, issues one at a time with
// operands held for the FPU latency, and returns the captured result on a valid/ready channel.
//
// state | meaning
// IDLE  | no op in flight; pops the FIFO head when one is available
// WAIT  | operands on the FPU, counting down its fixed latency
// RESP  | response held on rsp_* until the consumer accepts it
module fpu_cmd_issuer #(
    parameter int DEPTH   = 4,
    parameter int FPU_LAT = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [31:0]                cmd_a,
    input  logic [31:0]                cmd_b,
    input  logic [2:0]                 cmd_opc,
    output logic [31:0]                fpu_a,
    output logic [31:0]                fpu_b,
    output logic [2:0]                 fpu_opc,
    input  logic [31:0]                fpu_out,
    input  logic                       fpu_aeb,
    input  logic                       fpu_alb,
    input  logic                       fpu_agb,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [31:0]                rsp_data,
    output logic [2:0]                 rsp_flags,
    output logic                       rsp_err,
    output logic                       busy,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(FPU_LAT + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

    state_t          state, state_nxt;
    logic [66:0]     mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   cnt;
    logic [66:0]     head;
    logic            push, pop, illegal;

    assign cmd_ready = (level < LW'(DEPTH));
    assign push      = cmd_valid && cmd_ready;
    assign head      = mem[rd_ptr];
    // Opcodes 6 and 7 have no FPU meaning; they are answered with an error response.
    assign illegal   = head[2] & head[1];

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            ST_IDLE: if (level != '0) begin
                pop       = 1'b1;
                state_nxt = illegal ? ST_RESP : ST_WAIT;
            end
            ST_WAIT: if (cnt == CW'(1)) state_nxt = ST_RESP;
            ST_RESP: if (rsp_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        rsp_valid = (state == ST_RESP);
        busy      = (state != ST_IDLE) || (level != '0);
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {cmd_a, cmd_b, cmd_opc};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            cnt       <= '0;
            fpu_a     <= '0;
            fpu_b     <= '0;
            fpu_opc   <= '0;
            rsp_data  <= '0;
            rsp_flags <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
            if (pop && !illegal) begin
                fpu_a   <= head[66:35];
                fpu_b   <= head[34:3];
                fpu_opc <= head[2:0];
                cnt     <= CW'(FPU_LAT);
            end else if (pop) begin
                rsp_data  <= '0;
                rsp_flags <= '0;
                rsp_err   <= 1'b1;
            end
            if (state == ST_WAIT) begin
                cnt <= cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    rsp_data  <= fpu_out;
                    rsp_flags <= {fpu_aeb, fpu_alb, fpu_agb};
                    rsp_err   <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_fpu_cmd_issuer.sv
// Directed bench for fpu_cmd_issuer with a simple XOR/compare FPU stub.
module tb_fpu_cmd_issuer;

    localparam int DEPTH   = 4;
    localparam int FPU_LAT = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_a = '0, cmd_b = '0;
    logic [2:0]  cmd_opc = '0;
    logic [31:0] fpu_a, fpu_b;
    logic [2:0]  fpu_opc;
    logic [31:0] fpu_out;
    logic        fpu_aeb, fpu_alb, fpu_agb;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_data;
    logic [2:0]  rsp_flags;
    logic        rsp_err;
    logic        busy;
    logic [$clog2(DEPTH):0] level;

    int tests = 0;
    int fails = 0;

    fpu_cmd_issuer #(.DEPTH(DEPTH), .FPU_LAT(FPU_LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_opc(cmd_opc),
        .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_opc(fpu_opc),
        .fpu_out(fpu_out), .fpu_aeb(fpu_aeb), .fpu_alb(fpu_alb), .fpu_agb(fpu_agb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_flags(rsp_flags), .rsp_err(rsp_err),
        .busy(busy), .level(level)
    );

    always #5 clk = ~clk;

    // The operand registers inside the DUT are the first of the FPU_LAT stages,
    // so the stub adds FPU_LAT-1 (here one) further register stage.
    always_ff @(posedge clk) begin
        fpu_out <= fpu_a ^ fpu_b;
        fpu_aeb <= (fpu_a == fpu_b);
        fpu_alb <= (fpu_a <  fpu_b);
        fpu_agb <= (fpu_a >  fpu_b);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic wait_valid(input int budget, output int waited);
        waited = 0;
        while (rsp_valid !== 1'b1 && waited < budget) begin
            tick();
            waited++;
        end
    endtask

    logic [31:0] exp_a [5];
    logic [31:0] exp_b [5];
    logic [31:0] got_d [$];
    logic [2:0]  got_f [$];
    int          gaps  [$];
    int          w, last, cyc, stale;
    logic [31:0] hold_d;

    initial begin
        // Reset state
        tick(); tick();
        chk("rst_level", 32'(level), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_fpu_a", fpu_a, 0);
        chk("rst_rsp_err", 32'(rsp_err), 0);
        chk("rst_cmd_ready", 32'(cmd_ready), 1);
        rst_n = 1'b1;
        tick();

        // Single op
        cmd_valid = 1'b1; cmd_a = 32'h4124CCCD; cmd_b = 32'h4029999A; cmd_opc = 3'd0;
        tick();
        cmd_valid = 1'b0;
        chk("single_level_push", 32'(level), 1);
        chk("single_busy", 32'(busy), 1);
        tick();
        chk("single_issue_a", fpu_a, 32'h4124CCCD);
        chk("single_issue_opc", 32'(fpu_opc), 0);
        chk("single_level_pop", 32'(level), 0);
        chk("single_no_early_valid", 32'(rsp_valid), 0);
        tick();
        chk("single_no_early_valid2", 32'(rsp_valid), 0);
        tick();
        chk("single_valid", 32'(rsp_valid), 1);
        chk("single_data", rsp_data, 32'h010D5557);
        chk("single_flags", 32'(rsp_flags), 32'b001);
        chk("single_err", 32'(rsp_err), 0);
        tick();
        chk("single_valid_drop", 32'(rsp_valid), 0);
        chk("single_busy_drop", 32'(busy), 0);

        // Fill with backpressure: 6 offers, c0 issued, c1..c4 queued, c5 refused
        rsp_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            exp_a[k] = 32'h100 + 32'(k);
            exp_b[k] = (k % 2 == 0) ? 32'h10 : 32'h200;
        end
        for (int k = 0; k < 5; k++) begin
            cmd_valid = 1'b1; cmd_a = exp_a[k]; cmd_b = exp_b[k]; cmd_opc = 3'd1;
            tick();
        end
        chk("fill_level4", 32'(level), 4);
        chk("fill_cmd_ready_low", 32'(cmd_ready), 0);
        cmd_a = 32'hDEAD0005; cmd_b = 32'h0; cmd_opc = 3'd2;
        tick(); tick(); tick();
        chk("fill_level_held", 32'(level), 4);
        chk("fill_rsp_held", 32'(rsp_valid), 1);
        cmd_valid = 1'b0;

        // Drain: record every handshake and the spacing between them
        rsp_ready = 1'b1;
        last = 0;
        for (cyc = 0; cyc < 60 && got_d.size() < 5; cyc++) begin
            if (rsp_valid) begin
                got_d.push_back(rsp_data);
                got_f.push_back(rsp_flags);
                if (got_d.size() > 1) gaps.push_back(cyc - last);
                last = cyc;
            end
            tick();
        end
        chk("drain_count", 32'(got_d.size()), 5);
        for (int k = 0; k < got_d.size(); k++) begin
            chk($sformatf("drain_data%0d", k), got_d[k], exp_a[k] ^ exp_b[k]);
            chk($sformatf("drain_flags%0d", k), 32'(got_f[k]),
                (k % 2 == 0) ? 32'b001 : 32'b010);
        end
        for (int k = 0; k < gaps.size(); k++)
            chk($sformatf("drain_gap%0d", k), 32'(gaps[k]), FPU_LAT + 2);
        chk("drain_busy_low", 32'(busy), 0);
        chk("drain_level0", 32'(level), 0);

        // Illegal opcode: error response, FPU operands untouched
        cmd_valid = 1'b1; cmd_a = 32'h40000000; cmd_b = 32'h0; cmd_opc = 3'd7;
        tick();
        cmd_valid = 1'b0;
        tick();
        chk("ill_valid", 32'(rsp_valid), 1);
        chk("ill_err", 32'(rsp_err), 1);
        chk("ill_data", rsp_data, 0);
        chk("ill_flags", 32'(rsp_flags), 0);
        chk("ill_fpu_a_kept", fpu_a, 32'h104);
        chk("ill_fpu_opc_kept", 32'(fpu_opc), 1);
        tick();
        chk("ill_valid_drop", 32'(rsp_valid), 0);

        // Equal operands, then 10 cycles of backpressure
        rsp_ready = 1'b0;
        cmd_valid = 1'b1; cmd_a = 32'h3F800000; cmd_b = 32'h3F800000; cmd_opc = 3'd5;
        tick();
        cmd_valid = 1'b0;
        wait_valid(20, w);
        chk("eq_valid_in_budget", 32'(rsp_valid), 1);
        chk("eq_opc", 32'(fpu_opc), 5);
        chk("eq_err", 32'(rsp_err), 0);
        chk("eq_data", rsp_data, 0);
        chk("eq_flags", 32'(rsp_flags), 32'b100);
        hold_d = rsp_data;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk($sformatf("bp_valid%0d", k), 32'(rsp_valid), 1);
            chk($sformatf("bp_flags%0d", k), 32'(rsp_flags), 32'b100);
            chk($sformatf("bp_fpu_a%0d", k), fpu_a, 32'h3F800000);
        end
        rsp_ready = 1'b1;
        tick();
        chk("bp_release", 32'(rsp_valid), 0);

        // Reset during WAIT with two commands queued
        for (int k = 0; k < 3; k++) begin
            cmd_valid = 1'b1; cmd_a = 32'h7000 + 32'(k); cmd_b = 32'h1; cmd_opc = 3'd2;
            tick();
        end
        cmd_valid = 1'b0;
        chk("mid_level2", 32'(level), 2);
        chk("mid_inflight_a", fpu_a, 32'h7000);
        rst_n = 1'b0;
        tick();
        chk("mid_rst_level", 32'(level), 0);
        chk("mid_rst_valid", 32'(rsp_valid), 0);
        chk("mid_rst_fpu_a", fpu_a, 0);
        chk("mid_rst_fpu_opc", 32'(fpu_opc), 0);
        chk("mid_rst_cmd_ready", 32'(cmd_ready), 1);
        chk("mid_rst_busy", 32'(busy), 0);
        rst_n = 1'b1;
        stale = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (rsp_valid || busy) stale++;
        end
        chk("mid_no_stale", 32'(stale), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
